// File: rtl/mem_access_pkg.sv
// Shared ISA constants, FSM encodings and opcode classification helpers
// for the MEM pipeline stage.
package mem_access_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LD  = 6'h37;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SD  = 6'h3f;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'b0};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_BEAT0 = ST_BEAT0,
        S_BEAT1 = ST_BEAT1,
        S_DONE  = ST_DONE
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_dword(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: byte enables, replicated store data,
// misalignment detection and sign-extended halfword load data.
module mem_access_align
    import mem_access_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       op,
    input  logic [2:0]       addr_lo,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic             misalign,
    output logic [WIDTH-1:0] load_data
);

    logic        is_half;
    logic [15:0] half_sel;

    assign is_half  = (op == OP_LH) || (op == OP_SH);
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        misalign  = 1'b0;
        load_data = rdata;
        if (is_half) begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata    = {store_data[15:0], store_data[15:0]};
            misalign = addr_lo[0];
        end else if (is_dword(op)) begin
            misalign = |addr_lo;
        end else begin
            misalign = |addr_lo[1:0];
        end
        if (op == OP_LH) begin
            load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: request/acknowledge data-memory port with two-beat
// doubleword transfers, upstream stall, ack timeout and write-back outputs.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] Addr_in,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [WIDTH-1:0] Zhi_out,
    output logic             IsStall,
    output logic             MemErr,
    output logic             MemReq,
    output logic             MemWe,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic [3:0]       MemBE,
    input  logic [WIDTH-1:0] MemRData,
    input  logic             MemAck
);

    state_t           state_reg;
    logic [7:0]       cnt_reg;
    logic [WIDTH-1:0] ir_reg;
    logic [WIDTH-3:0] pc_reg;
    logic [WIDTH-1:0] z_reg;
    logic [WIDTH-1:0] zhi_reg;
    logic [2:0]       addr_lo_reg;

    logic [5:0]       op_in;
    logic [5:0]       op_reg;
    logic [5:0]       al_op;
    logic [2:0]       al_addr;
    logic [3:0]       al_be;
    logic [WIDTH-1:0] al_wdata;
    logic             al_misalign;
    logic [WIDTH-1:0] al_load;
    logic             beat_active;
    logic             timed_out;

    assign op_in  = IR_in[31:26];
    assign op_reg = ir_reg[31:26];

    // While idle the aligner looks at the incoming instruction; once an
    // access is in flight it works from the latched copy.
    assign al_op   = (state_reg == S_IDLE) ? op_in : op_reg;
    assign al_addr = (state_reg == S_IDLE) ? Addr_in[2:0] : addr_lo_reg;

    mem_access_align #(.WIDTH(WIDTH)) u_align (
        .op         (al_op),
        .addr_lo    (al_addr),
        .store_data (Z_in),
        .rdata      (MemRData),
        .be         (al_be),
        .wdata      (al_wdata),
        .misalign   (al_misalign),
        .load_data  (al_load)
    );

    // BEAT1 with MemReq low is the mandatory idle gap between beats.
    assign beat_active = (state_reg == S_BEAT0) || ((state_reg == S_BEAT1) && MemReq);
    assign timed_out   = beat_active && !MemAck && (cnt_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            ir_reg      <= NOP_INSTR;
            pc_reg      <= '0;
            z_reg       <= '0;
            zhi_reg     <= '0;
            addr_lo_reg <= '0;
            IR_out      <= NOP_INSTR;
            PC_out      <= '0;
            Z_out       <= '0;
            Zhi_out     <= '0;
            IsStall     <= 1'b0;
            MemErr      <= 1'b0;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            MemBE       <= '0;
        end else begin
            MemErr <= 1'b0;
            if (timed_out) begin
                MemReq    <= 1'b0;
                MemWe     <= 1'b0;
                MemErr    <= 1'b1;
                IsStall   <= 1'b0;
                IR_out    <= NOP_INSTR;
                Z_out     <= '0;
                Zhi_out   <= '0;
                state_reg <= S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (!is_mem_op(op_in)) begin
                            IR_out  <= IR_in;
                            PC_out  <= PC_in;
                            Z_out   <= Z_in;
                            Zhi_out <= '0;
                        end else if (al_misalign) begin
                            MemErr  <= 1'b1;
                            IR_out  <= NOP_INSTR;
                            PC_out  <= PC_in;
                            Z_out   <= '0;
                            Zhi_out <= '0;
                        end else begin
                            ir_reg      <= IR_in;
                            pc_reg      <= PC_in;
                            z_reg       <= Z_in;
                            zhi_reg     <= '0;
                            addr_lo_reg <= Addr_in[2:0];
                            MemReq      <= 1'b1;
                            IsStall     <= 1'b1;
                            MemWe       <= is_store(op_in);
                            MemAddr     <= {Addr_in[WIDTH-1:2], 2'b00};
                            MemBE       <= al_be;
                            MemWData    <= al_wdata;
                            cnt_reg     <= '0;
                            state_reg   <= S_BEAT0;
                        end
                    end
                    S_BEAT0: begin
                        if (MemAck) begin
                            if (is_load(op_reg)) begin
                                z_reg <= al_load;
                            end
                            MemReq    <= 1'b0;
                            state_reg <= is_dword(op_reg) ? S_BEAT1 : S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                    S_BEAT1: begin
                        if (!MemReq) begin
                            // The upper word of a 32-bit register is always zero.
                            MemReq   <= 1'b1;
                            MemAddr  <= MemAddr + WIDTH'(4);
                            MemWData <= '0;
                            cnt_reg  <= '0;
                        end else if (MemAck) begin
                            if (is_load(op_reg)) begin
                                zhi_reg <= MemRData;
                            end
                            MemReq    <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                    S_DONE: begin
                        IR_out    <= ir_reg;
                        PC_out    <= pc_reg;
                        Z_out     <= z_reg;
                        Zhi_out   <= zhi_reg;
                        IsStall   <= 1'b0;
                        MemWe     <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of single-cycle vectors plus
// hand-written multi-cycle memory access sequences.
module tb_mem_access;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LD  = 6'h37;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SD  = 6'h3f;
    localparam logic [31:0] NOP_W = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR_in, Z_in, Addr_in;
    logic [29:0] PC_in;
    logic [31:0] IR_out, Z_out, Zhi_out;
    logic [29:0] PC_out;
    logic        IsStall, MemErr, MemReq, MemWe, MemAck;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic [3:0]  MemBE;

    int checks = 0;
    int errors = 0;

    mem_access #(.WIDTH(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in), .Addr_in(Addr_in),
        .IR_out(IR_out), .PC_out(PC_out), .Z_out(Z_out), .Zhi_out(Zhi_out),
        .IsStall(IsStall), .MemErr(MemErr), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
        .MemRData(MemRData), .MemAck(MemAck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] z;
        logic [31:0] addr;
        logic [31:0] exp_ir;
        logic [31:0] exp_z;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h00abcde};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ir, input logic [31:0] z, input logic [31:0] addr);
        IR_in   = ir;
        Z_in    = z;
        Addr_in = addr;
    endtask

    initial begin
        int n;
        int stall_cycles;

        rst = 1'b1;
        IR_in = NOP_W; PC_in = '0; Z_in = '0; Addr_in = '0;
        MemRData = '0; MemAck = 1'b0;
        #3;
        chk("reset_ir", IR_out, NOP_W);
        chk("reset_z", Z_out, 32'h0);
        chk("reset_req_stall_err", {29'b0, MemReq, IsStall, MemErr}, 32'h0);
        chk("reset_be", {28'b0, MemBE}, 32'h0);
        step();
        rst = 1'b0;
        $display("txn reset ir_out=%h z_out=%h", IR_out, Z_out);

        vecs[0] = '{mk(OP_ADD), 30'h100, 32'h0000_1234, 32'h0,     mk(OP_ADD), 32'h0000_1234, 1'b0};
        vecs[1] = '{mk(OP_LW),  30'h101, 32'h5555_5555, 32'h401,   NOP_W,      32'h0,         1'b1};
        vecs[2] = '{mk(OP_ADD), 30'h102, 32'hA5A5_0001, 32'h3,     mk(OP_ADD), 32'hA5A5_0001, 1'b0};
        vecs[3] = '{mk(OP_LH),  30'h103, 32'h1,         32'h103,   NOP_W,      32'h0,         1'b1};
        vecs[4] = '{mk(OP_LD),  30'h104, 32'h2,         32'h30C,   NOP_W,      32'h0,         1'b1};
        vecs[5] = '{mk(OP_SW),  30'h105, 32'h3,         32'h202,   NOP_W,      32'h0,         1'b1};
        vecs[6] = '{mk(OP_SH),  30'h106, 32'h4,         32'h201,   NOP_W,      32'h0,         1'b1};
        vecs[7] = '{NOP_W,      30'h107, 32'hFFFF_FFFF, 32'h0,     NOP_W,      32'hFFFF_FFFF, 1'b0};

        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].ir, vecs[i].z, vecs[i].addr);
            PC_in = vecs[i].pc;
            step();
            chk($sformatf("vec%0d_ir", i), IR_out, vecs[i].exp_ir);
            chk($sformatf("vec%0d_pc", i), {2'b0, PC_out}, {2'b0, vecs[i].pc});
            chk($sformatf("vec%0d_z", i), Z_out, vecs[i].exp_z);
            chk($sformatf("vec%0d_zhi", i), Zhi_out, 32'h0);
            chk($sformatf("vec%0d_err", i), {31'b0, MemErr}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_req_stall", i), {30'b0, MemReq, IsStall}, 32'h0);
            $display("txn vec%0d ir_out=%h z_out=%h err=%0d", i, IR_out, Z_out, MemErr);
        end

        // LH, upper half, ack sampled on the third edge after the request
        set_in(mk(OP_LH), 32'h0, 32'h102);
        stall_cycles = 0;
        step();
        stall_cycles += IsStall;
        chk("lh_req", {31'b0, MemReq}, 32'h1);
        chk("lh_addr", MemAddr, 32'h100);
        chk("lh_be", {28'b0, MemBE}, 32'hC);
        chk("lh_we", {31'b0, MemWe}, 32'h0);
        set_in(mk(OP_ADD), 32'h7777, 32'h1);
        step(); stall_cycles += IsStall;
        step(); stall_cycles += IsStall;
        chk("lh_hold_addr", MemAddr, 32'h100);
        MemAck = 1'b1; MemRData = 32'h8001_0000;
        step(); stall_cycles += IsStall;
        chk("lh_done_req", {31'b0, MemReq}, 32'h0);
        MemAck = 1'b0; MemRData = '0;
        set_in(NOP_W, 32'h0, 32'h0);
        step(); stall_cycles += IsStall;
        chk("lh_z", Z_out, 32'hFFFF_8001);
        chk("lh_ir", IR_out, mk(OP_LH));
        chk("lh_stall_cycles", stall_cycles, 4);
        $display("txn lh z_out=%h stall_cycles=%0d", Z_out, stall_cycles);

        // SW with immediate ack
        set_in(mk(OP_SW), 32'hDEAD_BEEF, 32'h200);
        step();
        chk("sw_req_we", {30'b0, MemReq, MemWe}, 32'h3);
        chk("sw_be", {28'b0, MemBE}, 32'hF);
        chk("sw_wdata", MemWData, 32'hDEAD_BEEF);
        chk("sw_addr", MemAddr, 32'h200);
        MemAck = 1'b1;
        set_in(NOP_W, 32'h0, 32'h0);
        step();
        chk("sw_done_req", {30'b0, MemReq, IsStall}, 32'h1);
        MemAck = 1'b0;
        step();
        chk("sw_out", {IR_out[31:26], 25'b0, IsStall}, {OP_SW, 26'b0});
        $display("txn sw ir_out=%h", IR_out);

        // LD two beats with a one-cycle request gap
        set_in(mk(OP_LD), 32'h0, 32'h308);
        step();
        chk("ld_b0_addr", MemAddr, 32'h308);
        MemAck = 1'b1; MemRData = 32'h11;
        set_in(NOP_W, 32'h0, 32'h0);
        step();
        chk("ld_gap_req", {31'b0, MemReq}, 32'h0);
        MemAck = 1'b0; MemRData = '0;
        step();
        chk("ld_b1_req", {31'b0, MemReq}, 32'h1);
        chk("ld_b1_addr", MemAddr, 32'h30C);
        MemAck = 1'b1; MemRData = 32'h22;
        step();
        MemAck = 1'b0; MemRData = '0;
        chk("ld_done_stall", {30'b0, MemReq, IsStall}, 32'h1);
        step();
        chk("ld_z", Z_out, 32'h11);
        chk("ld_zhi", Zhi_out, 32'h22);
        chk("ld_stall", {31'b0, IsStall}, 32'h0);
        $display("txn ld z_out=%h zhi_out=%h", Z_out, Zhi_out);

        // SD: second beat writes zero at Addr+4
        set_in(mk(OP_SD), 32'hCAFE_F00D, 32'h310);
        step();
        chk("sd_b0_wdata", MemWData, 32'hCAFE_F00D);
        MemAck = 1'b1;
        set_in(NOP_W, 32'h0, 32'h0);
        step();
        MemAck = 1'b0;
        step();
        chk("sd_b1_addr", MemAddr, 32'h314);
        chk("sd_b1_wdata", MemWData, 32'h0);
        chk("sd_b1_req_we", {30'b0, MemReq, MemWe}, 32'h3);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        step();
        chk("sd_ir", IR_out, mk(OP_SD));
        $display("txn sd ir_out=%h", IR_out);

        // LW with no ack: timeout
        set_in(mk(OP_LW), 32'h0, 32'h400);
        step();
        set_in(NOP_W, 32'h0, 32'h0);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (MemErr) begin
                n = k;
                break;
            end
        end
        chk("to_edges", n, 255);
        chk("to_req_stall", {30'b0, MemReq, IsStall}, 32'h0);
        chk("to_ir", IR_out, NOP_W);
        step();
        chk("to_err_pulse", {31'b0, MemErr}, 32'h0);
        $display("txn timeout edges=%0d", n);

        // Ack coincides with the timeout edge: ack wins
        set_in(mk(OP_LW), 32'h0, 32'h404);
        step();
        set_in(NOP_W, 32'h0, 32'h0);
        for (int k = 1; k < 255; k++) step();
        MemAck = 1'b1; MemRData = 32'h1357_9BDF;
        step();
        MemAck = 1'b0; MemRData = '0;
        chk("race_err", {31'b0, MemErr}, 32'h0);
        chk("race_stall", {30'b0, MemReq, IsStall}, 32'h1);
        step();
        chk("race_z", Z_out, 32'h1357_9BDF);
        $display("txn ack_vs_timeout z_out=%h", Z_out);

        // Reset in BEAT0, ack arrives a cycle later
        set_in(mk(OP_LW), 32'h0, 32'h500);
        step();
        set_in(NOP_W, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req_stall", {30'b0, MemReq, IsStall}, 32'h0);
        chk("rst_mid_addr", MemAddr, 32'h0);
        chk("rst_mid_ir", IR_out, NOP_W);
        #1 rst = 1'b0;
        MemAck = 1'b1; MemRData = 32'hFFFF_0000;
        step();
        MemAck = 1'b0;
        chk("rst_late_ack", {29'b0, MemReq, IsStall, MemErr}, 32'h0);
        chk("rst_late_z", Z_out, 32'h0);
        $display("txn reset_mid_access z_out=%h req=%0d", Z_out, MemReq);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline MEM stage; sits directly downstream of the execute stage and consumes its outputs (IR, PC, Z, Addr).
- For load/store opcodes it drives a request/acknowledge data-memory port, including two-beat doubleword transfers.
- Aligns and sign-extends load data, stalls upstream while an access is outstanding, and forwards results to write-back.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- WIDTH, 32, datapath width; must match the global `WIDTH.
- TIMEOUT, 255, cycles to wait for MemAck before aborting the access (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IR_in  in  WIDTH  instruction from the execute stage
- PC_in  in  WIDTH-2  PC from the execute stage
- Z_in  in  WIDTH  ALU result, or store data for SW/SH/SD
- Addr_in  in  WIDTH  effective address for loads/stores
- IR_out  out  WIDTH  instruction to write-back
- PC_out  out  WIDTH-2  PC to write-back
- Z_out  out  WIDTH  ALU pass-through or load data (low word for LD)
- Zhi_out  out  WIDTH  high word for LD; 0 otherwise
- IsStall  out  1  holds the upstream stages while high
- MemErr  out  1  one-cycle pulse on misalignment or timeout
- MemReq  out  1  memory request
- MemWe  out  1  1 = write
- MemAddr  out  WIDTH  word-aligned address; bits [1:0] always 0
- MemWData  out  WIDTH  write data
- MemBE  out  4  byte enables
- MemRData  in  WIDTH  read data; valid when MemAck is high
- MemAck  in  1  access complete

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - IR_out = {`NOP,26'b0}; PC_out, Z_out, Zhi_out, MemAddr, MemWData = 0.
  - MemReq, MemWe, IsStall, MemErr = 0; MemBE = 0.
  - FSM = IDLE; timeout counter = 0. An in-flight access is abandoned; a late MemAck is ignored.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE, on each clk edge, decode the OpCode IR_in[31:26]:
  - Non-memory op: IR_out/PC_out/Z_out <= inputs; Zhi_out <= 0; stay in IDLE. Latency is 1 cycle.
  - Memory op, aligned: latch IR/PC/Z/Addr; assert MemReq, and IsStall in the same edge; go to BEAT0.
  - Alignment rules: LW/SW need Addr[1:0]==0; LH/SH need Addr[0]==0; LD/SD need Addr[2:0]==0.
  - Misaligned: no request; MemErr pulses 1 cycle; IR_out <= NOP; Z_out <= 0; stay in IDLE.
- Byte enables and write data:
  - Word and doubleword: MemBE = 4'b1111.
  - Halfword: MemBE = 4'b0011 if Addr[1]==0, else 4'b1100; MemWData = {Z[15:0],Z[15:0]}.
  - SD: beat 0 writes Z_in at Addr; beat 1 writes 0 at Addr+4 (upper word of a 32-bit register is 0).
- BEAT0:
  - MemReq, MemAddr, MemWe, MemBE and MemWData are held stable until MemAck is sampled high.
  - On MemAck, for a load: LW Z <= MemRData; LH Z <= sign-extended selected half (Addr[1] selects the upper half).
  - On MemAck, for LD/SD: drop MemReq for 1 cycle, then issue beat 1 at Addr+4 and go to BEAT1.
  - On MemAck, for any other op: go to DONE.
- BEAT1: on MemAck, LD captures Zhi <= MemRData; go to DONE.
- DONE:
  - MemReq = 0; present IR/PC/Z/Zhi on the outputs.
  - IsStall drops at this edge; return to IDLE.
  - An op is completed exactly once and the next instruction is accepted the following cycle.
- Timeout counter:
  - Resets on each new beat and increments each cycle MemReq is high without MemAck.
  - At TIMEOUT: abort (MemReq <= 0), pulse MemErr, IR_out <= NOP, clear IsStall, return to IDLE.
- Ignored inputs:
  - MemAck while MemReq is low.
  - IR_in/Z_in/Addr_in changes while IsStall is high (the latched copy is used).
- MemAck and the timeout in the same cycle: MemAck wins and no error is raised.
- Minimum latency: 3 cycles per single-beat access (request, ack, done); LD/SD take 5 or more.

Decomposition:
- OpCodes (LW, LH, LD, SW, SH, SD, NOP) come from the shared ISA definitions; `WIDTH comes from the shared params.
- Add a shared constant for the NOP instruction word and localparams for the FSM encodings.
- One combinational sub-module, mem_align: maps (opcode, Addr[1:0], store data, read data) to byte enables, replicated write data, a misalign flag and extended load data. The FSM, counter and registers stay in mem_access.

Test Plan:
- ADD, Z_in=0x1234 -> next cycle Z_out=0x1234, IsStall stays 0, MemReq stays 0.
- LH, Addr=0x102, MemRData=0x8001_0000, ack after 2 cycles -> MemAddr=0x100, MemBE=4'b1100, Z_out=0xFFFF_8001, IsStall high 4 cycles.
- SW, Addr=0x200, Z_in=0xDEADBEEF, ack immediate -> one write (MemWe=1, MemBE=4'b1111, MemWData=0xDEADBEEF), DONE, IDLE.
- LD, Addr=0x308, words 0x11, 0x22 -> beats at 0x308 and 0x30C, Z_out=0x11, Zhi_out=0x22, MemReq low 1 cycle between beats.
- LW, Addr=0x401 -> MemErr pulses 1 cycle, no MemReq, IR_out=NOP; LW with no MemAck -> MemErr after 255 cycles, IsStall cleared.
- rst asserted in BEAT0 with ack arriving 1 cycle later -> all outputs at reset values immediately, FSM in IDLE, the late ack produces no output change.
